rx_bit_timer: RTL and testbench



---
 rtl/rx_bit_timer_pkg.sv | 19 +
 rtl/rx_bit_timer_if.sv | 19 +
 rtl/rx_flex_counter.sv | 32 +++
 rtl/rx_bit_timer.sv | 85 ++++++++
 tb/tb_rx_bit_timer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/rx_bit_timer_pkg.sv
// Shared types and constants for the UART receive bit timer.
package rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int MIN_PERIOD        = 2;
  localparam int DEFAULT_DATA_SIZE = 8;
  localparam int STOP_BITS         = 1;

  // Frame sizes outside 5..8 fall back to the default size.
  function automatic logic [3:0] legal_size(input logic [3:0] size);
    return (size >= 4'd5 && size <= 4'd8) ? size : 4'(DEFAULT_DATA_SIZE);
  endfunction

endpackage

// File: rtl/rx_bit_timer_if.sv
// Control-unit <-> bit-timer signal bundle.
interface rx_bit_timer_if #(parameter int MAX_PERIOD_W = 14);
  logic                    enable_timer;
  logic [MAX_PERIOD_W-1:0] bit_period;
  logic [3:0]              data_size;
  logic                    shift_strobe;
  logic                    packet_done;
  logic [3:0]              bit_index;

  modport master (
    output enable_timer, bit_period, data_size,
    input  shift_strobe, packet_done, bit_index
  );

  modport slave (
    input  enable_timer, bit_period, data_size,
    output shift_strobe, packet_done, bit_index
  );
endinterface

// File: rtl/rx_flex_counter.sv
// Up-counter running 1..rollover_val with a registered rollover flag.
module rx_flex_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             count_en,
  input  logic [WIDTH-1:0] rollover_val,
  output logic [WIDTH-1:0] count,
  output logic             rollover_flag
);

  logic [WIDTH-1:0] count_next;

  assign count_next = (count == rollover_val) ? WIDTH'(1) : count + WIDTH'(1);

  // The flag marks the edge the count lands on rollover_val, so it pulses
  // in the same cycle the count first shows that value.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count         <= '0;
      rollover_flag <= 1'b0;
    end else if (count_en) begin
      count         <= count_next;
      rollover_flag <= (count_next == rollover_val);
    end else begin
      rollover_flag <= 1'b0;
    end
  end

endmodule

// File: rtl/rx_bit_timer.sv
// UART receive bit timer: per-bit sample strobes and end-of-packet pulse.
module rx_bit_timer
  import rx_pkg::*;
#(
  parameter int MAX_PERIOD_W = 14
) (
  input logic           clk,
  input logic           rst,
  rx_bit_timer_if.slave bus
);

  state_t                  state;
  logic                    enable_q;
  logic [MAX_PERIOD_W-1:0] period_q;
  logic [MAX_PERIOD_W-1:0] cyc_count;
  logic [3:0]              size_q;
  logic [3:0]              bit_count;
  logic [3:0]              bit_roll;
  logic                    rise;
  logic                    run_cnt;
  logic                    cyc_en;
  logic                    strobe_event;
  logic                    stop_event;
  logic                    cyc_flag;
  logic                    bit_flag;

  assign rise         = bus.enable_timer && !enable_q;
  assign run_cnt      = (state == RUN) && bus.enable_timer;
  assign cyc_en       = ((state == IDLE) && rise) || run_cnt;
  assign strobe_event = run_cnt && (cyc_count == period_q - MAX_PERIOD_W'(1));
  assign bit_roll     = size_q + 4'(STOP_BITS);
  assign stop_event   = strobe_event && (bit_count + 4'd1 == bit_roll);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      enable_q <= 1'b0;
      period_q <= '0;
      size_q   <= '0;
    end else begin
      enable_q <= bus.enable_timer;
      if (!bus.enable_timer) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (rise) begin
            state    <= RUN;
            period_q <= (bus.bit_period < MAX_PERIOD_W'(MIN_PERIOD)) ?
                        MAX_PERIOD_W'(MIN_PERIOD) : bus.bit_period;
            size_q   <= legal_size(bus.data_size);
          end
          RUN:     if (stop_event) state <= HOLD;
          HOLD:    state <= HOLD;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Dropping enable clears both counters, which also kills any pending strobe.
  rx_flex_counter #(.WIDTH(MAX_PERIOD_W)) u_cycle_cnt (
    .clk          (clk),
    .rst          (rst),
    .clear        (!bus.enable_timer),
    .count_en     (cyc_en),
    .rollover_val (period_q),
    .count        (cyc_count),
    .rollover_flag(cyc_flag)
  );

  rx_flex_counter #(.WIDTH(4)) u_bit_cnt (
    .clk          (clk),
    .rst          (rst),
    .clear        (!bus.enable_timer),
    .count_en     (strobe_event),
    .rollover_val (bit_roll),
    .count        (bit_count),
    .rollover_flag(bit_flag)
  );

  assign bus.shift_strobe = cyc_flag;
  assign bus.packet_done  = bit_flag;
  assign bus.bit_index    = bit_count;

endmodule

// File: tb/tb_rx_bit_timer.sv
// Directed bench for rx_bit_timer; edge 1 is the first edge enable is sampled high.
module tb_rx_bit_timer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  rx_bit_timer_if #(.MAX_PERIOD_W(14)) bus ();

  rx_bit_timer #(.MAX_PERIOD_W(14)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Expected outputs after edge e of a packet with period p and size s.
  function automatic logic exp_strobe(input int e, input int p, input int s);
    int k;
    k = e / p;
    return (e % p == 0) && (k >= 1) && (k <= s + 1);
  endfunction

  function automatic logic exp_done(input int e, input int p, input int s);
    return e == p * (s + 1);
  endfunction

  function automatic int exp_idx(input int e, input int p, input int s);
    int k;
    k = e / p;
    return (k > s + 1) ? s + 1 : k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.enable_timer = 1'b1;
    bus.bit_period   = 14'd2;
    bus.data_size    = 4'd5;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({bus.shift_strobe, bus.packet_done, bus.bit_index} !== 6'd0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got strobe=%b done=%b idx=%0d want 0/0/0",
                 i, bus.shift_strobe, bus.packet_done, bus.bit_index);
      end
    end
    bus.enable_timer = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.shift_strobe, bus.packet_done, bus.bit_index} !== 6'd0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got strobe=%b done=%b idx=%0d want 0/0/0",
                 i, bus.shift_strobe, bus.packet_done, bus.bit_index);
      end
    end
  endtask

  task automatic test_p10_s8();
    bus.bit_period   = 14'd10;
    bus.data_size    = 4'd8;
    bus.enable_timer = 1'b1;
    for (int e = 1; e <= 95; e++) begin
      tick();
      checks++;
      if (bus.shift_strobe !== exp_strobe(e, 10, 8) || bus.packet_done !== exp_done(e, 10, 8) ||
          bus.bit_index !== 4'(exp_idx(e, 10, 8))) begin
        errors++;
        $display("FAIL p10_s8 edge=%0d got strobe=%b done=%b idx=%0d want %b/%b/%0d", e,
                 bus.shift_strobe, bus.packet_done, bus.bit_index,
                 exp_strobe(e, 10, 8), exp_done(e, 10, 8), exp_idx(e, 10, 8));
      end
    end
    bus.enable_timer = 1'b0;
    tick();
    checks++;
    if (bus.bit_index !== 4'd0) begin
      errors++;
      $display("FAIL p10_s8_drop got idx=%0d want 0", bus.bit_index);
    end
  endtask

  task automatic test_mid_change();
    bus.bit_period   = 14'd4;
    bus.data_size    = 4'd5;
    bus.enable_timer = 1'b1;
    for (int e = 1; e <= 28; e++) begin
      tick();
      if (e == 6) begin
        bus.bit_period = 14'd7;
        bus.data_size  = 4'd8;
      end
      checks++;
      if (bus.shift_strobe !== exp_strobe(e, 4, 5) || bus.packet_done !== exp_done(e, 4, 5) ||
          bus.bit_index !== 4'(exp_idx(e, 4, 5))) begin
        errors++;
        $display("FAIL mid_change edge=%0d got strobe=%b done=%b idx=%0d want %b/%b/%0d", e,
                 bus.shift_strobe, bus.packet_done, bus.bit_index,
                 exp_strobe(e, 4, 5), exp_done(e, 4, 5), exp_idx(e, 4, 5));
      end
    end
    bus.enable_timer = 1'b0;
    tick();
  endtask

  task automatic test_clamp();
    bus.bit_period   = 14'd0;
    bus.data_size    = 4'd12;
    bus.enable_timer = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      tick();
      checks++;
      if (bus.shift_strobe !== exp_strobe(e, 2, 8) || bus.packet_done !== exp_done(e, 2, 8) ||
          bus.bit_index !== 4'(exp_idx(e, 2, 8))) begin
        errors++;
        $display("FAIL clamp edge=%0d got strobe=%b done=%b idx=%0d want %b/%b/%0d", e,
                 bus.shift_strobe, bus.packet_done, bus.bit_index,
                 exp_strobe(e, 2, 8), exp_done(e, 2, 8), exp_idx(e, 2, 8));
      end
    end
    bus.enable_timer = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    // Enable is low at edge 9, where the 3rd strobe of a period-3 packet would register.
    bus.bit_period   = 14'd3;
    bus.data_size    = 4'd6;
    bus.enable_timer = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (bus.shift_strobe !== exp_strobe(e, 3, 6) || bus.bit_index !== 4'(exp_idx(e, 3, 6))) begin
        errors++;
        $display("FAIL abort_pre edge=%0d got strobe=%b idx=%0d want %b/%0d", e,
                 bus.shift_strobe, bus.bit_index, exp_strobe(e, 3, 6), exp_idx(e, 3, 6));
      end
    end
    bus.enable_timer = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({bus.shift_strobe, bus.packet_done, bus.bit_index} !== 6'd0) begin
        errors++;
        $display("FAIL abort_post cyc=%0d got strobe=%b done=%b idx=%0d want 0/0/0",
                 i, bus.shift_strobe, bus.packet_done, bus.bit_index);
      end
    end
    bus.bit_period   = 14'd3;
    bus.data_size    = 4'd5;
    bus.enable_timer = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      checks++;
      if (bus.shift_strobe !== exp_strobe(e, 3, 5) || bus.packet_done !== exp_done(e, 3, 5) ||
          bus.bit_index !== 4'(exp_idx(e, 3, 5))) begin
        errors++;
        $display("FAIL abort_restart edge=%0d got strobe=%b done=%b idx=%0d want %b/%b/%0d", e,
                 bus.shift_strobe, bus.packet_done, bus.bit_index,
                 exp_strobe(e, 3, 5), exp_done(e, 3, 5), exp_idx(e, 3, 5));
      end
    end
    bus.enable_timer = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    bus.bit_period = 14'd3;
    bus.data_size  = 4'd5;
    for (int pkt = 0; pkt < 2; pkt++) begin
      bus.enable_timer = 1'b1;
      for (int e = 1; e <= 19; e++) begin
        tick();
        checks++;
        if (bus.shift_strobe !== exp_strobe(e, 3, 5) || bus.packet_done !== exp_done(e, 3, 5) ||
            bus.bit_index !== 4'(exp_idx(e, 3, 5))) begin
          errors++;
          $display("FAIL back_to_back pkt=%0d edge=%0d got strobe=%b done=%b idx=%0d want %b/%b/%0d",
                   pkt, e, bus.shift_strobe, bus.packet_done, bus.bit_index,
                   exp_strobe(e, 3, 5), exp_done(e, 3, 5), exp_idx(e, 3, 5));
        end
      end
      bus.enable_timer = 1'b0;
      tick();
      checks++;
      if ({bus.shift_strobe, bus.packet_done, bus.bit_index} !== 6'd0) begin
        errors++;
        $display("FAIL back_to_back_gap pkt=%0d got strobe=%b done=%b idx=%0d want 0/0/0",
                 pkt, bus.shift_strobe, bus.packet_done, bus.bit_index);
      end
    end
  endtask

  initial begin
    bus.enable_timer = 1'b0;
    bus.bit_period   = '0;
    bus.data_size    = '0;
    test_reset();
    test_p10_s8();
    test_mid_change();
    test_clamp();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
